// File: rtl/song_recorder.sv
// song_recorder: turns note / tempo strobes into 16-bit song words, buffers
// them in a small FIFO and writes them to consecutive memory words with a
// REQ/ACK handshake, closing every take with an end marker word.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_rec                    record level; rising edge starts a take, falling ends it
//   i_note_stb, i_mode,
//   i_tone, i_note           note strobe and its fields
//   i_bpm_stb, i_bpm         tempo strobe and value
//   i_stop                   end-of-take pulse
//   o_mem_req, o_mem_addr,
//   o_mem_data, i_mem_ack    memory write handshake
//   o_busy, o_full, o_err,
//   o_words, o_done          status
module song_recorder #(
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter logic [22:0] MAX_ADDR   = 23'h7FFFFF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rec,
  input  logic        i_note_stb,
  input  logic [1:0]  i_mode,
  input  logic [5:0]  i_tone,
  input  logic [3:0]  i_note,
  input  logic        i_bpm_stb,
  input  logic [7:0]  i_bpm,
  input  logic        i_stop,
  output logic        o_mem_req,
  output logic [22:0] o_mem_addr,
  output logic [15:0] o_mem_data,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_err,
  output logic [15:0] o_words,
  output logic        o_done
);
  localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  // Words that may be accepted so the end marker still fits at MAX_ADDR.
  localparam logic [22:0] CAP      = MAX_ADDR - BASE_ADDR;
  localparam logic [15:0] END_MARK = 16'hC000;

  typedef enum logic [2:0] {S_IDLE, S_RECORD, S_DRAIN, S_TERM, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          r_rec_d;
  logic [15:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic [22:0]   r_acc;
  logic          r_mem_req;
  logic [22:0]   r_mem_addr;
  logic [15:0]   r_mem_data;
  logic          r_err;
  logic [15:0]   r_words;

  logic        w_rise, w_fall, w_start, w_ack, w_full, w_stb;
  logic        w_ok, w_enq, w_pop, w_cap_rej, w_rej;
  logic [15:0] w_word;

  always_comb begin
    w_rise    = i_rec & ~r_rec_d;
    w_fall    = ~i_rec & r_rec_d;
    w_start   = (r_state == S_IDLE) & w_rise;
    w_ack     = r_mem_req & i_mem_ack;
    w_full    = (r_count == DEPTH_C);
    w_stb     = (r_state == S_RECORD) & (i_note_stb | i_bpm_stb);
    // BPM wins a same-cycle collision; the note is dropped with an error.
    w_word    = i_bpm_stb ? {2'b11, 6'b000000, i_bpm} : {i_mode, i_tone, 4'b0000, i_note};
    w_ok      = i_bpm_stb ? (i_bpm != 8'd0) : (i_mode != 2'b11);
    w_cap_rej = w_stb & w_ok & ~w_full & (r_acc >= CAP);
    w_enq     = w_stb & w_ok & ~w_full & ~(r_acc >= CAP);
    w_rej     = w_stb & (~w_ok | w_full | w_cap_rej | (i_note_stb & i_bpm_stb));
    // The end marker is never in the FIFO, so its ack must not pop.
    w_pop     = w_ack & (r_state != S_TERM);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_rise) w_next = S_RECORD;
      S_RECORD: if (i_stop | w_fall | w_cap_rej) w_next = S_DRAIN;
      S_DRAIN:  if ((r_count == '0) && !r_mem_req) w_next = S_TERM;
      S_TERM:   if (w_ack) w_next = S_DONE;
      S_DONE:   if (!i_rec) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_busy = (r_state == S_RECORD) | (r_state == S_DRAIN) | (r_state == S_TERM);
    o_done = (r_state == S_DONE);
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_fifo[r_wptr] <= w_word;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rec_d    <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_acc      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= BASE_ADDR;
      r_mem_data <= 16'h0000;
      r_err      <= 1'b0;
      r_words    <= 16'h0000;
    end else begin
      r_rec_d <= i_rec;
      if (w_start) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_acc      <= '0;
        r_mem_req  <= 1'b0;
        r_mem_addr <= BASE_ADDR;
        r_err      <= 1'b0;
        r_words    <= 16'h0000;
      end else begin
        if (w_rej) r_err <= 1'b1;
        if (w_enq) begin
          r_wptr <= r_wptr + PW'(1);
          r_acc  <= r_acc + 23'd1;
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + {{PW{1'b0}}, w_enq} - {{PW{1'b0}}, w_pop};
        // Writer: the FIFO head stays queued until acked. When the FIFO is
        // empty the incoming word is forwarded so REQ rises one edge after
        // the strobe.
        if (w_ack) begin
          r_mem_req  <= 1'b0;
          r_mem_addr <= r_mem_addr + 23'd1;
          if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
        end else if (!r_mem_req) begin
          if (((r_state == S_RECORD) || (r_state == S_DRAIN)) && ((r_count != '0) || w_enq)) begin
            r_mem_req  <= 1'b1;
            r_mem_data <= (r_count != '0) ? r_fifo[r_rptr] : w_word;
          end else if (r_state == S_TERM) begin
            r_mem_req  <= 1'b1;
            r_mem_data <= END_MARK;
          end
        end
      end
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_full     = w_full;
  assign o_err      = r_err;
  assign o_words    = r_words;
endmodule

// File: tb/tb_song_recorder.sv
module tb_song_recorder;
  localparam int          DEPTH = 4;
  localparam logic [22:0] BASE  = 23'h000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rec, note_stb, bpm_stb, stop, ack;
  logic [1:0] mode;
  logic [5:0] tone;
  logic [3:0] note;
  logic [7:0] bpm;
  logic req, busy, full, err, done;
  logic [22:0] addr;
  logic [15:0] data, words;
  logic c_req, c_busy, c_full, c_err, c_done;
  logic [22:0] c_addr;
  logic [15:0] c_data, c_words;

  song_recorder #(.BASE_ADDR(BASE), .MAX_ADDR(23'h7FFFFF), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rec(rec), .i_note_stb(note_stb), .i_mode(mode),
    .i_tone(tone), .i_note(note), .i_bpm_stb(bpm_stb), .i_bpm(bpm), .i_stop(stop),
    .o_mem_req(req), .o_mem_addr(addr), .o_mem_data(data), .i_mem_ack(ack),
    .o_busy(busy), .o_full(full), .o_err(err), .o_words(words), .o_done(done));

  song_recorder #(.BASE_ADDR(23'h000100), .MAX_ADDR(23'h000103), .FIFO_DEPTH(DEPTH)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_rec(rec), .i_note_stb(note_stb), .i_mode(mode),
    .i_tone(tone), .i_note(note), .i_bpm_stb(bpm_stb), .i_bpm(bpm), .i_stop(stop),
    .o_mem_req(c_req), .o_mem_addr(c_addr), .o_mem_data(c_data), .i_mem_ack(ack),
    .o_busy(c_busy), .o_full(c_full), .o_err(c_err), .o_words(c_words), .o_done(c_done));

  int checks = 0, failures = 0;
  logic [38:0] wq[$];
  logic [38:0] cq[$];

  always @(posedge clk) begin
    if (req && ack)   wq.push_back({addr, data});
    if (c_req && ack) cq.push_back({c_addr, c_data});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {4'b0, req, addr, data, busy, full, err, words, done};
  endfunction

  task automatic quiet();
    note_stb = 0; bpm_stb = 0; stop = 0; mode = 0; tone = 0; note = 0; bpm = 0;
  endtask

  // Stop the take and act as an always-ready memory until DONE.
  task automatic finish_take(input string nm);
    bit got;
    got = 0;
    ack = req; stop = 1; tick(); stop = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      ack = req;
      tick();
      if (done) got = 1;
    end
    ack = 0;
    chk({nm, "_done"}, got, 1);
  endtask

  task automatic end_take();
    rec = 0; tick();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic rec, nstb; logic [1:0] mode; logic [5:0] tone; logic [3:0] note;
    logic bstb; logic [7:0] bpm; logic stop, ack;
    logic e_req; logic [22:0] e_addr; logic [15:0] e_data;
    logic e_busy, e_full, e_err; logic [15:0] e_words; logic e_done;
  } vec_t;
  vec_t tv [9];

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 recording, 2 draining, 3 writing end marker, 4 done.
  int          m_ph, m_acc;
  logic [15:0] m_q[$];
  bit          m_req, m_err, m_rec_d;
  logic [15:0] m_data, m_words;
  logic [22:0] m_addr;

  task automatic model_step();
    bit rise, fall, acked, caprej, ok;
    int nph, old_sz;
    logic [15:0] w;
    if (!rst_n) begin
      m_ph = 0; m_q.delete(); m_req = 0; m_addr = BASE; m_data = 0;
      m_err = 0; m_words = 0; m_rec_d = 0; m_acc = 0;
      return;
    end
    rise = rec && !m_rec_d; fall = !rec && m_rec_d; acked = m_req && ack;
    if (m_ph == 0) begin
      if (rise) begin
        m_ph = 1; m_q.delete(); m_addr = BASE; m_words = 0; m_err = 0; m_acc = 0;
      end
      m_rec_d = rec;
      return;
    end
    old_sz = m_q.size(); caprej = 0;
    if (m_ph == 1 && (note_stb || bpm_stb)) begin
      if (note_stb && bpm_stb) m_err = 1;
      w  = bpm_stb ? {8'hC0, bpm} : {mode, tone, 4'h0, note};
      ok = bpm_stb ? (bpm != 0) : (mode != 2'b11);
      if (!ok || old_sz == DEPTH) m_err = 1;
      else if (m_acc >= int'(23'h7FFFFF - BASE)) begin m_err = 1; caprej = 1; end
      else begin m_q.push_back(w); m_acc++; end
    end
    nph = m_ph;
    case (m_ph)
      1: if (stop || fall || caprej) nph = 2;
      2: if (old_sz == 0 && !m_req) nph = 3;
      3: if (acked) nph = 4;
      4: if (!rec) nph = 0;
      default: ;
    endcase
    if (acked) begin
      if (m_ph != 3) void'(m_q.pop_front());
      m_req = 0; m_addr = m_addr + 1;
      if (m_words != 16'hFFFF) m_words = m_words + 1;
    end else if (!m_req) begin
      if ((m_ph == 1 || m_ph == 2) && m_q.size() > 0) begin m_req = 1; m_data = m_q[0]; end
      else if (m_ph == 3) begin m_req = 1; m_data = 16'hC000; end
    end
    m_ph = nph; m_rec_d = rec;
  endtask

  function automatic logic [63:0] m_outs();
    return {4'b0, m_req, m_addr, m_data, (m_ph >= 1 && m_ph <= 3), (m_q.size() == DEPTH),
            m_err, m_words, (m_ph == 4)};
  endfunction

  initial begin
    rst_n = 0; rec = 0; ack = 0; quiet();
    tick(); tick();
    chk("reset_state", outs(), {4'b0, 1'b0, BASE, 16'h0, 3'b000, 16'h0, 1'b0});
    rst_n = 1; tick();

    // Basic take: one staccato note, then the end marker.
    tv[0] = '{1,0,0,0,0,0,0,0,0, 0,0,16'h0000,   1,0,0,0,0};
    tv[1] = '{1,1,1,6'h15,4'h4,0,0,0,0, 1,0,16'h5504, 1,0,0,0,0};
    tv[2] = '{1,0,0,0,0,0,0,0,0, 1,0,16'h5504,   1,0,0,0,0};
    tv[3] = '{1,0,0,0,0,0,0,0,1, 0,1,16'h5504,   1,0,0,1,0};
    tv[4] = '{1,0,0,0,0,0,0,1,0, 0,1,16'h5504,   1,0,0,1,0};
    tv[5] = '{1,0,0,0,0,0,0,0,0, 0,1,16'h5504,   1,0,0,1,0};
    tv[6] = '{1,0,0,0,0,0,0,0,0, 1,1,16'hC000,   1,0,0,1,0};
    tv[7] = '{1,0,0,0,0,0,0,0,1, 0,2,16'hC000,   0,0,0,2,1};
    tv[8] = '{0,0,0,0,0,0,0,0,0, 0,2,16'hC000,   0,0,0,2,0};
    for (int i = 0; i < 9; i++) begin
      rec = tv[i].rec; note_stb = tv[i].nstb; mode = tv[i].mode; tone = tv[i].tone;
      note = tv[i].note; bpm_stb = tv[i].bstb; bpm = tv[i].bpm; stop = tv[i].stop; ack = tv[i].ack;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {4'b0, tv[i].e_req, tv[i].e_addr, tv[i].e_data, tv[i].e_busy, tv[i].e_full,
           tv[i].e_err, tv[i].e_words, tv[i].e_done});
    end
    quiet(); ack = 0;

    // Stalled BPM write keeps request fields stable.
    wq.delete();
    rec = 1; tick();
    bpm_stb = 1; bpm = 8'd120; tick(); quiet();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bpm_stall%0d", i), {req, addr, data}, {1'b1, BASE, 16'hC078});
      tick();
    end
    ack = 1; tick(); ack = 0;
    chk("bpm_acked", {req, addr, words}, {1'b0, 23'd1, 16'd1});
    tick(); tick();
    chk("bpm_one_write", wq.size(), 1);
    finish_take("bpm");
    end_take();

    // Strobes in IDLE are ignored without error.
    note_stb = 1; bpm_stb = 1; bpm = 0; tick(); quiet();
    chk("idle_ignore", {req, busy, err}, 3'b000);

    // FIFO overflow with memory stalled.
    wq.delete();
    rec = 1; tick();
    for (int k = 0; k < 5; k++) begin
      note_stb = 1; tone = 6'(k + 1); note = 4'(k + 1); tick();
      if (k == 3) chk("fifo_full", {full, err}, 2'b10);
    end
    quiet();
    chk("fifo_overflow_err", {full, err}, 2'b11);
    finish_take("ovf");
    chk("ovf_nwrites", wq.size(), 5);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ovf_w%0d", k), wq[k], {23'(k), 2'b00, 6'(k + 1), 4'h0, 4'(k + 1)});
    if (wq.size() == 5) chk("ovf_marker", wq[4], {23'd4, 16'hC000});
    chk("ovf_words", words, 5);
    end_take();

    // Same-cycle NOTE and BPM: only the BPM word is kept.
    wq.delete();
    rec = 1; tick();
    note_stb = 1; tone = 1; note = 1; bpm_stb = 1; bpm = 8'd60; tick(); quiet();
    chk("collide", {req, data, err}, {1'b1, 16'hC03C, 1'b1});
    finish_take("coll");
    chk("coll_n", wq.size(), 2);
    if (wq.size() == 2) chk("coll_marker", wq[1], {23'd1, 16'hC000});
    end_take();

    // Illegal mode, then zero BPM; each rejected, each new take clears ERR.
    for (int t = 0; t < 2; t++) begin
      wq.delete();
      rec = 1; tick();
      chk($sformatf("err_clear%0d", t), err, 0);
      if (t == 0) begin note_stb = 1; mode = 2'b11; tone = 5; note = 2; end
      else begin bpm_stb = 1; bpm = 0; end
      tick(); quiet();
      chk($sformatf("illegal%0d", t), {req, err}, 2'b01);
      finish_take($sformatf("ill%0d", t));
      chk($sformatf("illegal%0d_writes", t), wq.size(), 1);
      end_take();
    end

    // Reset while a write is pending.
    rec = 1; tick();
    note_stb = 1; tone = 3; note = 3; tick();
    tone = 4; note = 4; tick(); quiet();
    ack = 1; tick(); ack = 0; tick();
    chk("pre_reset", {req, addr}, {1'b1, 23'd1});
    rst_n = 0; rec = 0; tick();
    chk("mid_reset", outs(), {4'b0, 1'b0, BASE, 16'h0, 3'b000, 16'h0, 1'b0});
    rst_n = 1; tick();
    rec = 1; tick();
    note_stb = 1; tone = 7; note = 9; tick(); quiet();
    chk("restart", {req, addr, data, busy, words}, {1'b1, BASE, 16'h0709, 1'b1, 16'h0});
    finish_take("restart");
    chk("restart_words", words, 2);

    // Capacity limit on the small instance: 3 notes then the marker at MAX.
    rst_n = 0; rec = 0; tick(); rst_n = 1; tick();
    cq.delete();
    ack = 1; rec = 1; tick();
    for (int k = 0; k < 5; k++) begin
      note_stb = 1; tone = 6'(k + 1); note = 4'(k + 1); tick();
    end
    quiet();
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin tick(); if (c_done) got = 1; end
      chk("cap_done", got, 1);
    end
    ack = 0;
    chk("cap_n", cq.size(), 4);
    for (int k = 0; k < 3 && k < cq.size(); k++)
      chk($sformatf("cap_w%0d", k), cq[k], {23'h100 + 23'(k), 2'b00, 6'(k + 1), 4'h0, 4'(k + 1)});
    if (cq.size() == 4) chk("cap_marker", cq[3], {23'h103, 16'hC000});
    chk("cap_status", {c_err, c_done, c_words}, {1'b1, 1'b1, 16'd4});
    end_take();

    // Randomized run against the reference model.
    rst_n = 0; rec = 0; quiet(); ack = 0;
    model_step(); tick();
    chk("rnd_reset", outs(), m_outs());
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom % 500) != 0;
      if ($urandom % 50 == 0) rec = ~rec;
      note_stb = ($urandom % 4) == 0;
      bpm_stb  = ($urandom % 8) == 0;
      mode     = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      tone     = 6'($urandom);
      note     = 4'($urandom);
      bpm      = ($urandom % 16 == 0) ? 8'd0 : 8'($urandom);
      stop     = ($urandom % 80) == 0;
      ack      = m_req ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      model_step();
      tick();
      chk($sformatf("rnd%0d", c), outs(), m_outs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 Parameter BASE_ADDR, default 23'h000000, first word address of the recorded song.
REQ-002 Parameter MAX_ADDR, default 23'h7FFFFF, last writable word address; reserved for the end marker when reached.
REQ-003 Parameter FIFO_DEPTH, default 4, number of encoded words buffered; power of two.
REQ-004 CLK  in  1  100MHz clock; all logic on rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 REC  in  1  record enable level; rising edge starts a take, falling edge ends it.
REQ-007 NOTE_STB  in  1  one-cycle pulse: encode and enqueue a note word.
REQ-008 MODE  in  2  articulation: 00 normal, 01 staccato, 10 slurred; 11 illegal on NOTE_STB.
REQ-009 TONE  in  6  tone index.
REQ-010 NOTE  in  4  duration code.
REQ-011 BPM_STB  in  1  one-cycle pulse: enqueue a BPM command word.
REQ-012 BPM  in  8  tempo; 0 illegal on BPM_STB.
REQ-013 STOP  in  1  one-cycle pulse: end the take.
REQ-014 MEM_REQ  out  1  write request to memory controller.
REQ-015 MEM_ADDR  out  23  word address, stable while MEM_REQ high.
REQ-016 MEM_DATA  out  16  word data, stable while MEM_REQ high.
REQ-017 MEM_ACK  in  1  write complete; valid only while MEM_REQ high.
REQ-018 BUSY  out  1  high in every state except IDLE and DONE.
REQ-019 FULL  out  1  FIFO holds FIFO_DEPTH words.
REQ-020 ERR  out  1  sticky error flag; cleared only by reset or a new take.
REQ-021 WORDS  out  16  count of words acknowledged this take, end marker included; saturates at 16'hFFFF.
REQ-022 DONE  out  1  high while in DONE state.

Function
REQ-023 Note word encoding: {MODE, TONE, 4'b0000, NOTE}.
REQ-024 BPM word encoding: {2'b11, 6'b000000, BPM}.
REQ-025 End marker encoding: 16'hC000.
REQ-026 FSM states: IDLE, RECORD, DRAIN, TERM, DONE.
REQ-027 IDLE -> RECORD on REC 0->1 (registered edge detect): address := BASE_ADDR, WORDS := 0, FIFO flushed, ERR := 0.
REQ-028 Strobes are accepted in RECORD only; they are ignored without ERR in every other state.
REQ-029 RECORD -> DRAIN on a STOP pulse, on REC falling, or on a capacity reject (REQ-034).
REQ-030 DRAIN -> TERM when the FIFO is empty and MEM_REQ is low.
REQ-031 TERM: write the end marker at the current address; on its MEM_ACK go to DONE.
REQ-032 DONE -> IDLE in the first cycle REC is low; DONE holds for at least 1 cycle.
REQ-033 Rejects, each sets ERR and enqueues nothing:
- NOTE_STB with MODE=11
- BPM_STB with BPM=0
- any strobe while FULL (FULL sampled before a same-cycle pop)
REQ-034 Capacity: once accepted words reach MAX_ADDR-BASE_ADDR, a further accepted-type strobe is rejected, sets ERR, and forces RECORD -> DRAIN, so the end marker always lands at or before MAX_ADDR.
REQ-035 NOTE_STB and BPM_STB in the same cycle: BPM is enqueued; NOTE is dropped and ERR is set.
REQ-036 STOP in the same cycle as a valid strobe: the strobe is enqueued first, then the state moves to DRAIN.
REQ-037 Writer: MEM_REQ rises in the cycle after the FIFO head is valid and the state is RECORD or DRAIN (or TERM for the end marker).
REQ-038 On the edge MEM_ACK=1 with MEM_REQ=1:
- MEM_REQ falls and stays low for at least 1 cycle
- the FIFO pops
- address increments by 1
- WORDS increments by 1
REQ-039 Latency: NOTE_STB at cycle t with FIFO empty and writer idle -> MEM_REQ high at t+1 with the encoded data.
REQ-040 MEM_ACK while MEM_REQ is low is ignored.

Reset
REQ-041 While RST_N=0 at a clock edge:
- state := IDLE; FIFO emptied
- MEM_REQ := 0, MEM_ADDR := BASE_ADDR, MEM_DATA := 0
- BUSY := 0, FULL := 0, ERR := 0, WORDS := 0, DONE := 0
- REC edge detector loaded with 0
REQ-042 Reset mid-write abandons the pending word; MEM_REQ is low from the first reset edge.

Verification
REQ-043 REC rise; NOTE_STB MODE=01 TONE=6'h15 NOTE=4'h4; ACK after 2 cycles; STOP; ACK -> writes 16'h5504@0, 16'hC000@1; DONE=1; WORDS=2; ERR=0.
REQ-044 BPM_STB BPM=8'd120; MEM_ACK held low 10 cycles -> MEM_REQ, MEM_ADDR and MEM_DATA=16'hC078 stable throughout; one write on ACK.
REQ-045 With ACK held low, 5 NOTE_STBs -> 4 words queued; FULL=1; 5th dropped; ERR=1; after ACKs, exactly 4 words are written plus the end marker.
REQ-046 Same-cycle NOTE_STB+BPM_STB -> only the BPM word is written; ERR=1; NOTE_STB with MODE=11 and BPM_STB with BPM=0 are each rejected with ERR=1.
REQ-047 MAX_ADDR=BASE_ADDR+3: 5 NOTE_STBs -> 3 notes @0..2; end marker @3; ERR=1; DONE=1.
REQ-048 RST_N=0 while MEM_REQ=1 -> MEM_REQ=0 and all outputs at their reset values at the next edge; a new REC rise restarts at BASE_ADDR.
